// File: rtl/spi_cmd_blink_if.sv
// Signal bundle between the SPI slave receiver side and the command/blink stage.
// The slave modport is the command stage; master is whoever drives the SPI
// receiver outputs and observes the LED/status outputs.
interface spi_cmd_blink_if;
  logic       i_spi_rx_done;
  logic [7:0] i_spi_rx_data;
  logic       i_spi_cs_n;
  logic       o_led;
  logic [1:0] o_mode;
  logic [7:0] o_period;
  logic       o_cmd_err;

  modport slave (
    input  i_spi_rx_done,
    input  i_spi_rx_data,
    input  i_spi_cs_n,
    output o_led,
    output o_mode,
    output o_period,
    output o_cmd_err
  );

  modport master (
    output i_spi_rx_done,
    output i_spi_rx_data,
    output i_spi_cs_n,
    input  o_led,
    input  o_mode,
    input  o_period,
    input  o_cmd_err
  );
endinterface

// File: rtl/spi_cmd_blink.sv
// SPI command stage: syncs rx_done/cs_n, parses (opcode, arg) frames, drives LED blink engine.
// Latency: rx_done rise -> byte_valid SYNC_STAGES+1 cycles; arg byte_valid -> EXEC 1 cycle; EXEC -> regs next edge.
// No backpressure: bytes must be spaced >= SYNC_STAGES+3 cycles. Optional macro SPI_CMD_TIMEOUT_EN adds WAIT_ARG timeout.
module spi_cmd_blink #(
  parameter int TICK_DIV    = 12000,
  parameter int PERIOD_RST  = 250,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 65535
) (
  input logic            i_clk,
  input logic            i_rst,
  spi_cmd_blink_if.slave bus
);

  // Elaboration-time parameter sanity checks.
  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("TICK_DIV must be >= 1");
  end
  if (PERIOD_RST < 1 || PERIOD_RST > 255) begin : g_bad_period_rst
    $error("PERIOD_RST must be in 1..255");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYC must be in 1..65535");
  end

  localparam int             PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRESC_MAX   = PW'(TICK_DIV - 1);
  localparam logic [7:0]     PERIOD_INIT = 8'(PERIOD_RST);
  localparam logic [7:0]     OP_MODE     = 8'h01;
  localparam logic [7:0]     OP_PERIOD   = 8'h02;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_ARG, ST_EXEC} state_t;

  logic [SYNC_STAGES-1:0] r_done_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic                   r_done_d;
  logic                   r_byte_valid;
  logic [7:0]             r_rx_data;
  logic                   w_done_s;
  logic                   w_cs_s;

  state_t     r_state, w_state_nxt;
  logic       r_op_period;
  logic [7:0] r_arg;
  logic [1:0] r_mode;
  logic [7:0] r_period;
  logic       r_cmd_err;
  logic       w_err_nxt, w_op_we, w_arg_we, w_mode_we, w_period_we, w_write;
  logic       w_tmo_hit;

  logic [PW-1:0] r_presc;
  logic [7:0]    r_tick_cnt;
  logic          r_phase;
  logic          r_led;
  logic          w_tick;

  assign w_done_s = r_done_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];

  // Synchronisers (equal depth keeps done/cs event order) and byte_valid edge detect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_done_sync  <= '0;
      r_cs_sync    <= '1;
      r_done_d     <= 1'b0;
      r_byte_valid <= 1'b0;
      r_rx_data    <= 8'h00;
    end else begin
      r_done_sync  <= {r_done_sync[SYNC_STAGES-2:0], bus.i_spi_rx_done};
      r_cs_sync    <= {r_cs_sync[SYNC_STAGES-2:0], bus.i_spi_cs_n};
      r_done_d     <= w_done_s;
      r_byte_valid <= w_done_s & ~r_done_d;
      if (w_done_s & ~r_done_d) r_rx_data <= bus.i_spi_rx_data;
    end
  end

`ifdef SPI_CMD_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  // Cycles spent in WAIT_ARG; zero on the first WAIT_ARG cycle, so the hit
  // below fires on the TIMEOUT_CYC-th waiting cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                     r_tmo_cnt <= 16'd0;
    else if (r_state != ST_WAIT_ARG) r_tmo_cnt <= 16'd0;
    else                           r_tmo_cnt <= r_tmo_cnt + 16'd1;
  end

  assign w_tmo_hit = (r_state == ST_WAIT_ARG) && (r_tmo_cnt == 16'(TIMEOUT_CYC - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Frame parser: next state, register write enables and error request.
  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = 1'b0;
    w_op_we     = 1'b0;
    w_arg_we    = 1'b0;
    w_mode_we   = 1'b0;
    w_period_we = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_byte_valid) begin
          if (r_rx_data == OP_MODE || r_rx_data == OP_PERIOD) begin
            w_op_we     = 1'b1;
            w_state_nxt = ST_WAIT_ARG;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      ST_WAIT_ARG: begin
        if (r_byte_valid) begin
          w_arg_we    = 1'b1;
          w_state_nxt = ST_EXEC;
        end else if (w_cs_s || w_tmo_hit) begin
          w_err_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_IDLE;
        if (r_op_period) begin
          if (r_arg != 8'h00) w_period_we = 1'b1;
          else                w_err_nxt   = 1'b1;
        end else begin
          if (r_arg[1:0] != 2'd3) w_mode_we = 1'b1;
          else                    w_err_nxt = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_write = w_mode_we | w_period_we;

  // State, latched frame bytes, control registers and registered error pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_op_period <= 1'b0;
      r_arg       <= 8'h00;
      r_mode      <= 2'd2;
      r_period    <= PERIOD_INIT;
      r_cmd_err   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cmd_err <= w_err_nxt;
      if (w_op_we)     r_op_period <= (r_rx_data == OP_PERIOD);
      if (w_arg_we)    r_arg       <= r_rx_data;
      if (w_mode_we)   r_mode      <= r_arg[1:0];
      if (w_period_we) r_period    <= r_arg;
    end
  end

  assign w_tick = (r_presc == PRESC_MAX);

  // Blink engine: prescaler -> tick counter -> phase; restarted by any successful write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_presc    <= '0;
      r_tick_cnt <= 8'd0;
      r_phase    <= 1'b0;
    end else if (w_write) begin
      r_presc    <= '0;
      r_tick_cnt <= 8'd0;
      r_phase    <= 1'b0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        if (r_tick_cnt == r_period - 8'd1) begin
          r_tick_cnt <= 8'd0;
          r_phase    <= ~r_phase;
        end else begin
          r_tick_cnt <= r_tick_cnt + 8'd1;
        end
      end
    end
  end

  // Registered LED drive selected by mode.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_led <= 1'b0;
    end else begin
      case (r_mode)
        2'd0:    r_led <= 1'b0;
        2'd1:    r_led <= 1'b1;
        default: r_led <= r_phase;
      endcase
    end
  end

  assign bus.o_led     = r_led;
  assign bus.o_mode    = r_mode;
  assign bus.o_period  = r_period;
  assign bus.o_cmd_err = r_cmd_err;

endmodule
